// File: rtl/pitch_feed_arbiter.sv
// pitch_feed_arbiter
//   Merges two redundant BATS PITCH UDP feeds (line A / line B) onto the single
//   64-bit input of the bats_parser. The 8-byte Sequenced Unit Header of each
//   datagram is inspected. Only datagrams that carry new data for UNIT_ID are
//   forwarded. Line duplicates, stale datagrams, heartbeats and malformed
//   datagrams are dropped. The block also generates the parser's one-cycle
//   start-up reset and reports sequence and event status.
//
// Ports
//   Clk40, reset_n          : clock, asynchronous active-low reset
//   a_* / b_*               : feed words (data, keep, valid, last) and ready
//   resync                  : pulse; forget sequence sync at the next idle point
//   p_bytes/p_byte_enables  : word to the parser
//   p_data_valid / p_ready  : valid/ready handshake with the parser
//   p_reset                 : one-cycle parser reset after reset release
//   expected_seq            : next expected sequence number (0 = unsynced)
//   gap/drop/err_count      : saturating event counters
module pitch_feed_arbiter #(
  parameter logic [7:0] UNIT_ID     = 8'd1,
  parameter int         INIT_CYCLES = 16,
  parameter int         MAX_WORDS   = 190
) (
  input  logic        Clk40,
  input  logic        reset_n,
  input  logic [63:0] a_data,
  input  logic [7:0]  a_keep,
  input  logic        a_valid,
  input  logic        a_last,
  output logic        a_ready,
  input  logic [63:0] b_data,
  input  logic [7:0]  b_keep,
  input  logic        b_valid,
  input  logic        b_last,
  output logic        b_ready,
  input  logic        resync,
  output logic [63:0] p_bytes,
  output logic [7:0]  p_byte_enables,
  output logic        p_data_valid,
  input  logic        p_ready,
  output logic        p_reset,
  output logic [31:0] expected_seq,
  output logic [15:0] gap_count,
  output logic [15:0] drop_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_DECIDE,
    S_FWD_HDR,
    S_FWD_BODY,
    S_DROP
  } state_t;

  // The init counter must hold INIT_CYCLES+1 (pulse cycle plus idle cycles).
  localparam int INIT_W = $clog2(INIT_CYCLES + 2);

  state_t             r_state;
  state_t             w_state_next;
  logic [INIT_W-1:0]  r_init_cnt;
  logic               r_p_reset;
  logic               r_rr_b;        // tie-break priority: 1 = line B wins
  logic               r_gnt_b;       // line owning the current datagram
  logic [63:0]        r_hdr;
  logic [7:0]         r_hdr_keep;
  logic               r_hdr_last;
  logic [31:0]        r_expected;
  logic [15:0]        r_gap;
  logic [15:0]        r_drop;
  logic [15:0]        r_err;
  logic               r_resync_pend;
  logic [31:0]        r_byte_cnt;
  logic [15:0]        r_word_cnt;

  logic               w_idle_any;
  logic               w_idle_gnt_b;
  logic               w_gnt_b;
  logic [63:0]        w_sel_data;
  logic [7:0]         w_sel_keep;
  logic               w_sel_valid;
  logic               w_sel_last;
  logic               w_sel_ready;
  logic               w_accept;
  logic [3:0]         w_keep_ones;
  logic [31:0]        w_bytes_total;
  logic [16:0]        w_words_total;
  logic [7:0]         w_cnt;
  logic [31:0]        w_seq;
  logic [31:0]        w_seq_next;
  logic               w_fwd;
  logic               w_exp_load;
  logic               w_inc_gap;
  logic               w_inc_drop;
  logic               w_inc_err;
  logic               w_resync_any;

  // In IDLE the grant is decided combinationally so the header is taken in
  // the same cycle; afterwards the registered owner steers the mux.
  assign w_idle_any   = a_valid | b_valid;
  assign w_idle_gnt_b = b_valid & (~a_valid | r_rr_b);
  assign w_gnt_b      = (r_state == S_IDLE) ? w_idle_gnt_b : r_gnt_b;

  assign w_sel_data   = w_gnt_b ? b_data  : a_data;
  assign w_sel_keep   = w_gnt_b ? b_keep  : a_keep;
  assign w_sel_valid  = w_gnt_b ? b_valid : a_valid;
  assign w_sel_last   = w_gnt_b ? b_last  : a_last;
  assign w_accept     = w_sel_valid & w_sel_ready;

  // The non-granted line never sees ready.
  assign a_ready      = w_sel_ready & ~w_gnt_b;
  assign b_ready      = w_sel_ready &  w_gnt_b;

  assign w_cnt        = r_hdr[23:16];
  assign w_seq        = r_hdr[63:32];
  assign w_seq_next   = w_seq + {24'd0, w_cnt};

  always_comb begin
    w_keep_ones = '0;
    for (int i = 0; i < 8; i++) begin
      w_keep_ones = w_keep_ones + {3'd0, w_sel_keep[i]};
    end
  end

  // Totals including the word being accepted now (header counted as 8 bytes).
  assign w_bytes_total = r_byte_cnt + {28'd0, w_keep_ones};
  assign w_words_total = {1'b0, r_word_cnt} + 17'd1;

  // A resync seen in the very cycle that re-enters IDLE still applies.
  assign w_resync_any  = r_resync_pend | resync;

  always_comb begin
    w_state_next   = r_state;
    w_sel_ready    = 1'b0;
    p_bytes        = '0;
    p_byte_enables = '0;
    p_data_valid   = 1'b0;
    w_fwd          = 1'b0;
    w_exp_load     = 1'b0;
    w_inc_gap      = 1'b0;
    w_inc_drop     = 1'b0;
    w_inc_err      = 1'b0;

    case (r_state)
      S_INIT: begin
        if (r_init_cnt == INIT_W'(INIT_CYCLES + 1)) begin
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        w_sel_ready = w_idle_any;
        if (w_idle_any) begin
          w_state_next = S_DECIDE;
        end
      end

      S_DECIDE: begin
        if (r_hdr_keep != 8'hFF) begin
          w_inc_err = 1'b1;
        end else if (r_hdr[31:24] != UNIT_ID) begin
          w_inc_drop = 1'b1;
        end else if (w_cnt == 8'd0) begin
          // heartbeat: silently discarded
        end else if (r_hdr_last) begin
          w_inc_err = 1'b1;    // messages announced but no body present
        end else if ((r_expected == 32'd0) || (w_seq == r_expected)) begin
          w_fwd      = 1'b1;
          w_exp_load = 1'b1;
        end else if (w_seq < r_expected) begin
          w_inc_drop = 1'b1;   // already delivered by the other line
        end else begin
          w_fwd      = 1'b1;
          w_exp_load = 1'b1;
          w_inc_gap  = 1'b1;
        end
        // A header-only datagram has nothing left to discard upstream.
        if (w_fwd) begin
          w_state_next = S_FWD_HDR;
        end else if (r_hdr_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DROP;
        end
      end

      S_FWD_HDR: begin
        p_bytes        = r_hdr;
        p_byte_enables = 8'hFF;
        p_data_valid   = 1'b1;
        if (p_ready) begin
          w_state_next = r_hdr_last ? S_IDLE : S_FWD_BODY;
        end
      end

      S_FWD_BODY: begin
        p_bytes        = w_sel_data;
        p_byte_enables = w_sel_keep;
        p_data_valid   = w_sel_valid;
        w_sel_ready    = p_ready;
        if (w_sel_valid && p_ready && w_sel_last) begin
          w_state_next = S_IDLE;
          if ((w_bytes_total != {16'd0, r_hdr[15:0]}) ||
              (w_words_total > 17'(MAX_WORDS))) begin
            w_inc_err = 1'b1;
          end
        end
      end

      S_DROP: begin
        w_sel_ready = 1'b1;
        if (w_sel_valid && w_sel_last) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge Clk40 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_INIT;
      r_init_cnt    <= '0;
      r_p_reset     <= 1'b0;
      r_rr_b        <= 1'b0;
      r_gnt_b       <= 1'b0;
      r_hdr         <= '0;
      r_hdr_keep    <= '0;
      r_hdr_last    <= 1'b0;
      r_expected    <= '0;
      r_gap         <= '0;
      r_drop        <= '0;
      r_err         <= '0;
      r_resync_pend <= 1'b0;
      r_byte_cnt    <= '0;
      r_word_cnt    <= '0;
    end else begin
      r_state <= w_state_next;

      // Pulse on the first edge after reset release only.
      r_p_reset <= (r_state == S_INIT) && (r_init_cnt == '0);
      if ((r_state == S_INIT) && (r_init_cnt != INIT_W'(INIT_CYCLES + 1))) begin
        r_init_cnt <= r_init_cnt + 1'b1;
      end

      if ((r_state == S_IDLE) && w_idle_any) begin
        r_hdr      <= w_sel_data;
        r_hdr_keep <= w_sel_keep;
        r_hdr_last <= w_sel_last;
        r_gnt_b    <= w_idle_gnt_b;
        r_rr_b     <= ~r_rr_b;
      end

      if (r_state == S_DECIDE) begin
        r_byte_cnt <= 32'd8;
        r_word_cnt <= 16'd1;
      end else if ((r_state == S_FWD_BODY) && w_accept) begin
        r_byte_cnt <= w_bytes_total;
        r_word_cnt <= w_words_total[16] ? 16'hFFFF : w_words_total[15:0];
      end

      if ((w_state_next == S_IDLE) && w_resync_any) begin
        r_expected    <= 32'd0;
        r_resync_pend <= 1'b0;
      end else begin
        if (w_exp_load) begin
          r_expected <= w_seq_next;
        end
        if (resync) begin
          r_resync_pend <= 1'b1;
        end
      end

      if (w_inc_gap && (r_gap != 16'hFFFF)) begin
        r_gap <= r_gap + 16'd1;
      end
      if (w_inc_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
      if (w_inc_err && (r_err != 16'hFFFF)) begin
        r_err <= r_err + 16'd1;
      end
    end
  end

  assign p_reset      = r_p_reset;
  assign expected_seq = r_expected;
  assign gap_count    = r_gap;
  assign drop_count   = r_drop;
  assign err_count    = r_err;

endmodule

// File: tb/tb_pitch_feed_arbiter.sv
// tb_pitch_feed_arbiter
//   Directed and randomized datagrams on both feed lines, with a random
//   parser back-pressure pattern. A datagram-level reference model decides
//   forward/drop and status updates from the header rules.
module tb_pitch_feed_arbiter;

  localparam logic [7:0] UNIT_ID     = 8'd1;
  localparam int         INIT_CYCLES = 16;
  localparam int         MAX_WORDS   = 6;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [63:0] a_data, b_data;
  logic [7:0]  a_keep, b_keep;
  logic        a_valid, b_valid, a_last, b_last, a_ready, b_ready;
  logic        resync;
  logic [63:0] p_bytes;
  logic [7:0]  p_byte_enables;
  logic        p_data_valid, p_ready, p_reset;
  logic [31:0] expected_seq;
  logic [15:0] gap_count, drop_count, err_count;

  pitch_feed_arbiter #(
    .UNIT_ID    (UNIT_ID),
    .INIT_CYCLES(INIT_CYCLES),
    .MAX_WORDS  (MAX_WORDS)
  ) dut (
    .Clk40         (clk),
    .reset_n       (reset_n),
    .a_data        (a_data),
    .a_keep        (a_keep),
    .a_valid       (a_valid),
    .a_last        (a_last),
    .a_ready       (a_ready),
    .b_data        (b_data),
    .b_keep        (b_keep),
    .b_valid       (b_valid),
    .b_last        (b_last),
    .b_ready       (b_ready),
    .resync        (resync),
    .p_bytes       (p_bytes),
    .p_byte_enables(p_byte_enables),
    .p_data_valid  (p_data_valid),
    .p_ready       (p_ready),
    .p_reset       (p_reset),
    .expected_seq  (expected_seq),
    .gap_count     (gap_count),
    .drop_count    (drop_count),
    .err_count     (err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] m_exp;
  int          m_gap, m_drop, m_err;
  bit          m_ptr_b;

  // staged datagrams, per-line word queues, expected/observed parser words
  logic [63:0] sa_data[$], sb_data[$];
  logic [7:0]  sa_keep[$], sb_keep[$];
  logic [63:0] qa_data[$], qb_data[$];
  logic [7:0]  qa_keep[$], qb_keep[$];
  bit          qa_last[$], qb_last[$], qa_first[$], qb_first[$];
  logic [63:0] ex_data[$], obs_data[$];
  logic [7:0]  ex_keep[$], obs_keep[$];

  int          cyc = 0;
  int          last_hdr_cyc = 0;
  bit          prev_valid = 0;
  bit          prev_stall = 0;
  logic [63:0] prev_bytes;
  logic [7:0]  prev_be;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic build(input bit to_b, input logic [31:0] seq, input logic [7:0] cnt,
                       input logic [7:0] unit, input int nbody, input int lastb,
                       input int adj, input logic [7:0] hkeep);
    logic [63:0] d[$];
    logic [7:0]  k[$];
    int          len;
    logic [7:0]  kb;
    len = (nbody == 0) ? 8 : 8 + 8 * (nbody - 1) + lastb;
    len = len + adj;
    kb  = 8'((1 << lastb) - 1);
    d.push_back({seq, unit, cnt, len[15:0]});
    k.push_back(hkeep);
    for (int i = 0; i < nbody; i++) begin
      d.push_back({$urandom(), $urandom()});
      k.push_back((i == nbody - 1) ? kb : 8'hFF);
    end
    if (to_b) begin sb_data = d; sb_keep = k; end
    else      begin sa_data = d; sa_keep = k; end
  endtask

  // Applies the header rules to one whole datagram in grant order.
  task automatic model_run(input bit is_b);
    logic [63:0] d[$];
    logic [7:0]  k[$];
    logic [31:0] seq;
    logic [7:0]  cnt, unit;
    logic [15:0] len;
    bit          fwd;
    int          bytes;
    if (is_b) begin d = sb_data; k = sb_keep; end
    else      begin d = sa_data; k = sa_keep; end
    len  = d[0][15:0];
    cnt  = d[0][23:16];
    unit = d[0][31:24];
    seq  = d[0][63:32];
    fwd  = 0;
    if (k[0] != 8'hFF)                    m_err++;
    else if (unit != UNIT_ID)             m_drop++;
    else if (cnt == 0)                    ;
    else if (d.size() == 1)               m_err++;
    else if (m_exp == 0 || seq == m_exp) begin fwd = 1; m_exp = seq + 32'(cnt); end
    else if (seq < m_exp)                 m_drop++;
    else begin fwd = 1; m_gap++; m_exp = seq + 32'(cnt); end
    if (fwd) begin
      bytes = 0;
      for (int i = 0; i < d.size(); i++) begin
        bytes += $countones(k[i]);
        ex_data.push_back(d[i]);
        ex_keep.push_back(k[i]);
      end
      if (bytes != int'(len) || d.size() > MAX_WORDS) m_err++;
    end
    m_ptr_b = !m_ptr_b;
  endtask

  task automatic run_traffic();
    int guard = 0;
    int tail  = 0;
    while (tail < 4) begin
      @(negedge clk);
      a_valid = (qa_data.size() > 0);
      a_data  = a_valid ? qa_data[0] : '0;
      a_keep  = a_valid ? qa_keep[0] : '0;
      a_last  = a_valid ? qa_last[0] : 1'b0;
      b_valid = (qb_data.size() > 0);
      b_data  = b_valid ? qb_data[0] : '0;
      b_keep  = b_valid ? qb_keep[0] : '0;
      b_last  = b_valid ? qb_last[0] : 1'b0;
      p_ready = ($urandom_range(0, 9) < 7);
      #1;
      cyc++;
      if (prev_stall) begin
        chk("hold_valid", 64'(p_data_valid), 64'd1);
        chk("hold_bytes", p_bytes, prev_bytes);
        chk("hold_be", 64'(p_byte_enables), 64'(prev_be));
      end
      chk("ready_exclusive", 64'(a_ready & b_ready), 64'd0);
      if (p_data_valid && !prev_valid) chk("hdr_latency", 64'(cyc - last_hdr_cyc), 64'd2);
      prev_valid = p_data_valid;
      prev_stall = p_data_valid && !p_ready;
      prev_bytes = p_bytes;
      prev_be    = p_byte_enables;
      if (p_data_valid && p_ready) begin
        obs_data.push_back(p_bytes);
        obs_keep.push_back(p_byte_enables);
      end
      if (a_valid && a_ready) begin
        if (qa_first[0]) last_hdr_cyc = cyc;
        void'(qa_data.pop_front()); void'(qa_keep.pop_front());
        void'(qa_last.pop_front()); void'(qa_first.pop_front());
      end
      if (b_valid && b_ready) begin
        if (qb_first[0]) last_hdr_cyc = cyc;
        void'(qb_data.pop_front()); void'(qb_keep.pop_front());
        void'(qb_last.pop_front()); void'(qb_first.pop_front());
      end
      if (qa_data.size() == 0 && qb_data.size() == 0) tail++;
      guard++;
      if (guard > 2000) begin
        chk("traffic_timeout", 64'(qa_data.size() + qb_data.size()), 64'd0);
        qa_data.delete(); qa_keep.delete(); qa_last.delete(); qa_first.delete();
        qb_data.delete(); qb_keep.delete(); qb_last.delete(); qb_first.delete();
        break;
      end
    end
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    #1;
  endtask

  task automatic check_status(input string tag);
    int n;
    chk($sformatf("%s_words", tag), 64'(obs_data.size()), 64'(ex_data.size()));
    n = (obs_data.size() < ex_data.size()) ? obs_data.size() : ex_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), obs_data[i], ex_data[i]);
      chk($sformatf("%s_keep%0d", tag, i), 64'(obs_keep[i]), 64'(ex_keep[i]));
    end
    chk($sformatf("%s_expected_seq", tag), 64'(expected_seq), 64'(m_exp));
    chk($sformatf("%s_gap", tag), 64'(gap_count), 64'(m_gap));
    chk($sformatf("%s_drop", tag), 64'(drop_count), 64'(m_drop));
    chk($sformatf("%s_err", tag), 64'(err_count), 64'(m_err));
    $display("step %s: words=%0d exp_seq=%0h gap=%0d drop=%0d err=%0d",
             tag, obs_data.size(), expected_seq, gap_count, drop_count, err_count);
    obs_data.delete(); obs_keep.delete(); ex_data.delete(); ex_keep.delete();
  endtask

  // Models the staged datagram(s) in grant order, loads the lines, runs.
  task automatic step(input string tag, input bit on_a, input bit on_b);
    bit first_b;
    if (on_a && on_b) begin
      first_b = m_ptr_b;
      model_run(first_b);
      model_run(!first_b);
    end else begin
      model_run(on_b);
    end
    if (on_a) for (int i = 0; i < sa_data.size(); i++) begin
      qa_data.push_back(sa_data[i]); qa_keep.push_back(sa_keep[i]);
      qa_last.push_back(i == sa_data.size() - 1); qa_first.push_back(i == 0);
    end
    if (on_b) for (int i = 0; i < sb_data.size(); i++) begin
      qb_data.push_back(sb_data[i]); qb_keep.push_back(sb_keep[i]);
      qb_last.push_back(i == sb_data.size() - 1); qb_first.push_back(i == 0);
    end
    run_traffic();
    check_status(tag);
  endtask

  task automatic gen_random(input bit to_b);
    logic [31:0] seq;
    logic [7:0]  cnt, unit, hkeep;
    int          r;
    r = $urandom_range(0, 9);
    if (r < 4)      seq = (m_exp == 0) ? 32'($urandom_range(1, 50)) : m_exp;
    else if (r < 6) seq = m_exp - 32'($urandom_range(1, 3));
    else if (r < 9) seq = m_exp + 32'($urandom_range(1, 5));
    else            seq = $urandom();
    cnt   = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
    unit  = ($urandom_range(0, 9) == 0) ? 8'd2 : UNIT_ID;
    hkeep = ($urandom_range(0, 19) == 0) ? 8'h7F : 8'hFF;
    build(to_b, seq, cnt, unit, $urandom_range(0, 6), $urandom_range(1, 8),
          ($urandom_range(0, 4) == 0) ? 1 : 0, hkeep);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pr_cnt, first_pr, first_rdy;
    bit gone, b_seen;
    int mode;

    reset_n = 0; resync = 0; p_ready = 1;
    a_valid = 0; a_data = '0; a_keep = '0; a_last = 0;
    b_valid = 0; b_data = '0; b_keep = '0; b_last = 0;
    m_exp = 0; m_gap = 0; m_drop = 0; m_err = 0; m_ptr_b = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_p_reset", 64'(p_reset), 64'd0);
    chk("rst_p_valid", 64'(p_data_valid), 64'd0);
    chk("rst_p_bytes", p_bytes, 64'd0);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    chk("rst_expected_seq", 64'(expected_seq), 64'd0);
    chk("rst_counters", 64'({gap_count, drop_count, err_count}), 64'd0);

    // A heartbeat waits on line A through the init window.
    build(0, 32'd0, 8'd0, UNIT_ID, 0, 1, 0, 8'hFF);
    model_run(0);
    a_valid = 1; a_data = sa_data[0]; a_keep = sa_keep[0]; a_last = 1;
    @(negedge clk);
    reset_n = 1;
    pr_cnt = 0; first_pr = 0; first_rdy = 0; gone = 0; b_seen = 0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (gone) a_valid = 0;
      #1;
      if (p_reset) begin pr_cnt++; if (first_pr == 0) first_pr = j; end
      if (b_ready) b_seen = 1;
      if (a_ready && a_valid && !gone) begin first_rdy = j; gone = 1; end
    end
    chk("p_reset_first_cycle", 64'(first_pr), 64'd1);
    chk("p_reset_width", 64'(pr_cnt), 64'd1);
    chk("init_ready_cycle", 64'(first_rdy), 64'(INIT_CYCLES + 2));
    chk("init_b_ready", 64'(b_seen), 64'd0);
    check_status("init_heartbeat");

    build(0, 32'd2, 8'd1, UNIT_ID, 1, 6, 0, 8'hFF);
    step("a_first", 1, 0);
    sb_data = sa_data; sb_keep = sa_keep;
    step("b_duplicate", 0, 1);
    build(0, 32'd5, 8'd2, UNIT_ID, 3, 2, 0, 8'hFF);
    step("a_gap", 1, 0);
    build(0, 32'd7, 8'd0, UNIT_ID, 0, 1, 0, 8'hFF);
    step("a_heartbeat", 1, 0);
    build(0, 32'd7, 8'd1, UNIT_ID, 1, 4, 0, 8'hFF);
    sb_data = sa_data; sb_keep = sa_keep;
    step("tie_same", 1, 1);
    build(0, 32'd8, 8'd1, 8'd2, 2, 3, 0, 8'hFF);
    step("unit_mismatch", 1, 0);
    build(0, 32'd8, 8'd1, UNIT_ID, 2, 6, 8, 8'hFF);
    step("length_err", 1, 0);
    build(1, 32'd9, 8'd1, UNIT_ID, 2, 5, 0, 8'h7F);
    step("keep_err", 0, 1);
    build(0, 32'd9, 8'd1, UNIT_ID, 0, 1, 0, 8'hFF);
    step("hdr_only_err", 1, 0);
    build(0, 32'd9, 8'd1, UNIT_ID, MAX_WORDS - 1, 8, 0, 8'hFF);
    step("max_words_ok", 1, 0);
    build(1, 32'd10, 8'd1, UNIT_ID, MAX_WORDS, 8, 0, 8'hFF);
    step("max_words_over", 0, 1);
    build(0, 32'd30, 8'd2, UNIT_ID, 2, 1, 0, 8'hFF);
    build(1, 32'd30, 8'd3, UNIT_ID, 1, 7, 0, 8'hFF);
    step("tie_diff", 1, 1);

    @(negedge clk); resync = 1;
    @(negedge clk); resync = 0;
    repeat (2) @(negedge clk);
    #1;
    m_exp = 0;
    chk("resync_expected_seq", 64'(expected_seq), 64'd0);
    build(0, 32'd3, 8'd2, UNIT_ID, 2, 4, 0, 8'hFF);
    step("after_resync", 1, 0);

    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin gen_random(0); step($sformatf("rnd%0d_a", s), 1, 0); end
        1: begin gen_random(1); step($sformatf("rnd%0d_b", s), 0, 1); end
        2: begin gen_random(0); sb_data = sa_data; sb_keep = sa_keep;
                 step($sformatf("rnd%0d_dup", s), 1, 1); end
        default: begin gen_random(0); gen_random(1);
                 step($sformatf("rnd%0d_both", s), 1, 1); end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
